// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-level sequencer for the pong display pipeline.
// Runs new game / serve / play / game-over, keeps a two-digit BCD hit score
// and the balls-remaining count, and freezes the graphics stage between balls.
// A once-per-frame tick, taken from the pixel coordinates, times the
// inter-ball and game-over delays.
// Optional feature macro: PONG_BONUS_BALL_EN (extra ball on every 10th hit,
// capped at BALLS).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// NEWGAME  | title screen, graphics frozen, any button starts a game
// PLAY     | ball live, hits scored, a miss ends the current ball
// NEWBALL  | delay before the next serve, button serves once timer is 0
// OVER     | game-over text for TIMER_TICKS frames, then back to NEWGAME
module pong_game_ctrl #(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls_left,
  output logic       st_newgame,
  output logic       st_over
);

  localparam logic [1:0] S_NEWGAME = 2'd0;
  localparam logic [1:0] S_PLAY    = 2'd1;
  localparam logic [1:0] S_NEWBALL = 2'd2;
  localparam logic [1:0] S_OVER    = 2'd3;

  localparam logic [1:0] BALLS_INIT = 2'(BALLS);
  localparam logic [7:0] TIMER_LOAD = 8'(TIMER_TICKS);

  logic [1:0] state_q, state_d;
  logic [3:0] d1_q, d1_d, d0_q, d0_d;
  logic [1:0] balls_q, balls_d;
  logic [7:0] timer_q, timer_d;
  logic       frame_q, frame_prev_q;
  logic       hit_r_q, miss_r_q;

  logic btn_any, tick, hit_ev, miss_ev, score_max;

  assign btn_any   = (|btn1) | (|btn2);
  assign tick      = frame_q & ~frame_prev_q;
  assign hit_ev    = hit & ~hit_r_q;
  assign miss_ev   = miss & ~miss_r_q;
  assign score_max = (d1_q == 4'd9) && (d0_q == 4'd9);

  // Next-state, score, ball count and delay timer for the game sequencer.
  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    balls_d = balls_q;
    timer_d = timer_q;
    case (state_q)
      S_NEWGAME: begin
        if (btn_any) begin
          d1_d    = 4'd0;
          d0_d    = 4'd0;
          balls_d = BALLS_INIT;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (hit_ev && !score_max) begin
          if (d0_q == 4'd9) begin
            d0_d = 4'd0;
            d1_d = d1_q + 4'd1;
`ifdef PONG_BONUS_BALL_EN
            if (balls_q < BALLS_INIT) balls_d = balls_q + 2'd1;
`endif
          end else begin
            d0_d = d0_q + 4'd1;
          end
        end
        // A miss in the same cycle as a hit still ends the ball; the miss
        // decides the ball count from the pre-hit value.
        if (miss_ev) begin
          timer_d = TIMER_LOAD;
          if (balls_q == 2'd1) begin
            balls_d = 2'd0;
            state_d = S_OVER;
          end else begin
            balls_d = balls_q - 2'd1;
            state_d = S_NEWBALL;
          end
        end
      end
      S_NEWBALL: begin
        if (timer_q == 8'd0) begin
          if (btn_any) state_d = S_PLAY;
        end else if (tick) begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_OVER: begin
        if (timer_q == 8'd0) state_d = S_NEWGAME;
        else if (tick) timer_d = timer_q - 8'd1;
      end
      default: state_d = S_NEWGAME;
    endcase
  end

  // State, counters and edge/tick history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_NEWGAME;
      d1_q         <= 4'd0;
      d0_q         <= 4'd0;
      balls_q      <= BALLS_INIT;
      timer_q      <= 8'd0;
      frame_q      <= 1'b0;
      frame_prev_q <= 1'b0;
      hit_r_q      <= 1'b0;
      miss_r_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      d1_q         <= d1_d;
      d0_q         <= d0_d;
      balls_q      <= balls_d;
      timer_q      <= timer_d;
      frame_q      <= (pix_x == 10'd0) && (pix_y == 10'd0);
      frame_prev_q <= frame_q;
      hit_r_q      <= hit;
      miss_r_q     <= miss;
    end
  end

  assign gra_still  = (state_q != S_PLAY);
  assign st_newgame = (state_q == S_NEWGAME);
  assign st_over    = (state_q == S_OVER);
  assign score_d1   = d1_q;
  assign score_d0   = d0_q;
  assign balls_left = balls_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl with a 4-frame delay timer.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn1, btn2;
  logic [9:0] pix_x, pix_y;
  logic       hit, miss;
  logic       gra_still, st_newgame, st_over;
  logic [3:0] score_d1, score_d0;
  logic [1:0] balls_left;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.BALLS(3), .TIMER_TICKS(4)) dut (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2),
    .pix_x(pix_x), .pix_y(pix_y), .hit(hit), .miss(miss),
    .gra_still(gra_still), .score_d1(score_d1), .score_d0(score_d0),
    .balls_left(balls_left), .st_newgame(st_newgame), .st_over(st_over)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hit_pulse();
    hit = 1'b1; cyc(1);
    hit = 1'b0; cyc(1);
  endtask

  task automatic miss_pulse();
    miss = 1'b1; cyc(1);
    miss = 1'b0; cyc(1);
  endtask

  task automatic press();
    btn1 = 2'b01; cyc(1);
    btn1 = 2'b00;
  endtask

  // One video frame: origin held 3 cycles, then elsewhere for 2 cycles.
  task automatic frame();
    pix_x = 10'd0; pix_y = 10'd0; cyc(3);
    pix_x = 10'd5; pix_y = 10'd7; cyc(2);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    btn1 = 2'b00; btn2 = 2'b00; hit = 1'b0; miss = 1'b0;
    pix_x = 10'd5; pix_y = 10'd7;
    do_reset();
    checks++;
    if (gra_still !== 1'b1 || st_newgame !== 1'b1 || st_over !== 1'b0 ||
        score_d1 !== 4'd0 || score_d0 !== 4'd0 || balls_left !== 2'd3) begin
      failures++;
      $display("FAIL reset: still=%b ng=%b over=%b score=%0d%0d balls=%0d, want 1 1 0 00 3",
               gra_still, st_newgame, st_over, score_d1, score_d0, balls_left);
    end
  endtask

  task automatic test_start();
    press();
    checks++;
    if (gra_still !== 1'b0 || st_newgame !== 1'b0 || score_d1 !== 4'd0 ||
        score_d0 !== 4'd0 || balls_left !== 2'd3) begin
      failures++;
      $display("FAIL start: still=%b ng=%b score=%0d%0d balls=%0d, want 0 0 00 3",
               gra_still, st_newgame, score_d1, score_d0, balls_left);
    end
  endtask

  task automatic test_hits();
    for (int i = 0; i < 12; i++) hit_pulse();
    checks++;
    if (score_d1 !== 4'd1 || score_d0 !== 4'd2) begin
      failures++;
      $display("FAIL hits12: score=%0d%0d want 12", score_d1, score_d0);
    end
    hit = 1'b1; cyc(5);
    hit = 1'b0; cyc(1);
    checks++;
    if (score_d1 !== 4'd1 || score_d0 !== 4'd3) begin
      failures++;
      $display("FAIL hit_held: score=%0d%0d want 13", score_d1, score_d0);
    end
  endtask

  task automatic test_newball();
    miss_pulse();
    checks++;
    if (balls_left !== 2'd2 || gra_still !== 1'b1 || st_over !== 1'b0 || st_newgame !== 1'b0) begin
      failures++;
      $display("FAIL newball_enter: balls=%0d still=%b over=%b ng=%b, want 2 1 0 0",
               balls_left, gra_still, st_over, st_newgame);
    end
    hit_pulse();
    checks++;
    if (score_d1 !== 4'd1 || score_d0 !== 4'd3) begin
      failures++;
      $display("FAIL hit_outside_play: score=%0d%0d want 13", score_d1, score_d0);
    end
    frame(); frame();
    press(); cyc(1);
    checks++;
    if (gra_still !== 1'b1) begin
      failures++;
      $display("FAIL early_btn: still=%b want 1", gra_still);
    end
    frame(); frame();
    checks++;
    if (gra_still !== 1'b1) begin
      failures++;
      $display("FAIL no_latch: still=%b want 1", gra_still);
    end
    press();
    checks++;
    if (gra_still !== 1'b0 || balls_left !== 2'd2) begin
      failures++;
      $display("FAIL serve: still=%b balls=%0d want 0 2", gra_still, balls_left);
    end
  endtask

  task automatic test_over();
    miss_pulse();
    for (int i = 0; i < 4; i++) frame();
    press();
    checks++;
    if (gra_still !== 1'b0 || balls_left !== 2'd1) begin
      failures++;
      $display("FAIL serve2: still=%b balls=%0d want 0 1", gra_still, balls_left);
    end
    miss_pulse();
    press(); cyc(1);
    checks++;
    if (st_over !== 1'b1 || balls_left !== 2'd0 || gra_still !== 1'b1) begin
      failures++;
      $display("FAIL over_enter: over=%b balls=%0d still=%b want 1 0 1",
               st_over, balls_left, gra_still);
    end
    frame(); frame(); frame();
    checks++;
    if (st_over !== 1'b1) begin
      failures++;
      $display("FAIL over_hold: over=%b want 1", st_over);
    end
    frame();
    checks++;
    if (st_newgame !== 1'b1 || st_over !== 1'b0 || score_d1 !== 4'd1 ||
        score_d0 !== 4'd3 || balls_left !== 2'd0) begin
      failures++;
      $display("FAIL over_exit: ng=%b over=%b score=%0d%0d balls=%0d want 1 0 13 0",
               st_newgame, st_over, score_d1, score_d0, balls_left);
    end
    btn2 = 2'b10; cyc(1); btn2 = 2'b00;
    checks++;
    if (score_d1 !== 4'd0 || score_d0 !== 4'd0 || balls_left !== 2'd3 || gra_still !== 1'b0) begin
      failures++;
      $display("FAIL restart: score=%0d%0d balls=%0d still=%b want 00 3 0",
               score_d1, score_d0, balls_left, gra_still);
    end
  endtask

  task automatic test_saturate();
    for (int i = 1; i <= 101; i++) begin
      hit_pulse();
      if (i == 10) begin
        checks++;
        if (score_d1 !== 4'd1 || score_d0 !== 4'd0) begin
          failures++;
          $display("FAIL bcd_carry: score=%0d%0d want 10", score_d1, score_d0);
        end
      end
      if (i == 98) begin
        checks++;
        if (score_d1 !== 4'd9 || score_d0 !== 4'd8) begin
          failures++;
          $display("FAIL score98: score=%0d%0d want 98", score_d1, score_d0);
        end
      end
    end
    checks++;
    if (score_d1 !== 4'd9 || score_d0 !== 4'd9) begin
      failures++;
      $display("FAIL saturate: score=%0d%0d want 99", score_d1, score_d0);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    press();
    for (int i = 0; i < 5; i++) hit_pulse();
    hit = 1'b1; miss = 1'b1; cyc(1);
    hit = 1'b0; miss = 1'b0; cyc(1);
    checks++;
    if (score_d1 !== 4'd0 || score_d0 !== 4'd6 || gra_still !== 1'b1 ||
        st_over !== 1'b0 || balls_left !== 2'd2) begin
      failures++;
      $display("FAIL hit_and_miss: score=%0d%0d still=%b over=%b balls=%0d want 06 1 0 2",
               score_d1, score_d0, gra_still, st_over, balls_left);
    end
  endtask

  task automatic test_reset_mid();
    frame();
    checks++;
    if (dut.timer_q !== 8'd3) begin
      failures++;
      $display("FAIL timer_dec: timer=%0d want 3", dut.timer_q);
    end
    reset = 1'b1; cyc(1); reset = 1'b0;
    checks++;
    if (st_newgame !== 1'b1 || dut.timer_q !== 8'd0 || score_d1 !== 4'd0 ||
        score_d0 !== 4'd0 || balls_left !== 2'd3) begin
      failures++;
      $display("FAIL reset_mid: ng=%b timer=%0d score=%0d%0d balls=%0d want 1 0 00 3",
               st_newgame, dut.timer_q, score_d1, score_d0, balls_left);
    end
    press();
    hit_pulse();
    hit = 1'b1; reset = 1'b1; cyc(1);
    hit = 1'b0; reset = 1'b0; cyc(1);
    checks++;
    if (st_newgame !== 1'b1 || score_d1 !== 4'd0 || score_d0 !== 4'd0) begin
      failures++;
      $display("FAIL reset_over_hit: ng=%b score=%0d%0d want 1 00",
               st_newgame, score_d1, score_d0);
    end
  endtask

  task automatic test_bonus();
    logic [1:0] exp10, exp20;
`ifdef PONG_BONUS_BALL_EN
    exp10 = 2'd3; exp20 = 2'd3;
`else
    exp10 = 2'd2; exp20 = 2'd2;
`endif
    press();
    miss_pulse();
    for (int i = 0; i < 4; i++) frame();
    press();
    for (int i = 0; i < 10; i++) hit_pulse();
    checks++;
    if (balls_left !== exp10) begin
      failures++;
      $display("FAIL bonus10: balls=%0d want %0d", balls_left, exp10);
    end
    for (int i = 0; i < 10; i++) hit_pulse();
    checks++;
    if (balls_left !== exp20 || score_d1 !== 4'd2 || score_d0 !== 4'd0) begin
      failures++;
      $display("FAIL bonus20: balls=%0d score=%0d%0d want %0d 20",
               balls_left, score_d1, score_d0, exp20);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_start();
    test_hits();
    test_newball();
    test_over();
    test_saturate();
    test_same_cycle();
    test_reset_mid();
    test_bonus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
